// File: rtl/fd_pkg.sv
// Shared types and helpers for the fetch/decode instruction queue.
// One queue entry carries a fetched instruction together with its PC+1.
package fd_pkg;

  localparam int REGI_SIZE = 16;
  localparam logic [REGI_SIZE-1:0] NOP_INSTR = 16'h0;

  typedef struct packed {
    logic [REGI_SIZE-1:0] instr;
    logic [REGI_SIZE-1:0] next_pc;
  } fd_entry_t;

  // The caller truncates the result to the pointer width, so a power-of-two
  // depth wraps for free.
  function automatic int unsigned ptr_inc(input int unsigned ptr);
    return ptr + 1;
  endfunction

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Handshake bundle between fetch, the instruction queue and decode.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
interface fetch_decode_queue_if #(
  parameter int REGI_SIZE = 16,
  parameter int DEPTH     = 4
);
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [REGI_SIZE-1:0]         instr_i;
  logic [REGI_SIZE-1:0]         next_pc_i;
  logic                         flush_i;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [REGI_SIZE-1:0]         instr_o;
  logic [REGI_SIZE-1:0]         next_pc_o;
  logic [$clog2(DEPTH+1)-1:0]   count_o;

  modport slave (
    input  in_valid_i, instr_i, next_pc_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, instr_o, next_pc_o, count_o
  );

  modport master (
    output in_valid_i, instr_i, next_pc_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, instr_o, next_pc_o, count_o
  );
endinterface

// File: rtl/fd_queue_mem.sv
// Entry storage for the instruction queue: one write port, one asynchronous read port.
// The array has no reset; occupancy tracking in the parent decides what is meaningful.
module fd_queue_mem
  import fd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_addr_i,
  input  fd_entry_t        wr_data_i,
  input  logic [PTR_W-1:0] rd_addr_i,
  output fd_entry_t        rd_data_o
);

  fd_entry_t mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry FIFO between fetch and decode with flush and a NOP bubble when empty.
// Full and popping still accepts a push, so decode never stalls fetch for a cycle needlessly.
module fetch_decode_queue
  import fd_pkg::*;
#(
  parameter int                   REGI_SIZE = fd_pkg::REGI_SIZE,
  parameter int                   DEPTH     = 4,
  parameter logic [REGI_SIZE-1:0] NOP_INSTR = fd_pkg::NOP_INSTR
) (
  input logic                 clk_i,
  input logic                 rst_i,
  fetch_decode_queue_if.slave bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic      push;
  logic      pop;
  logic      in_ready;
  logic      out_valid;
  logic      wr_en;
  fd_entry_t wr_entry;
  fd_entry_t rd_entry;

  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q < COUNT_W'(DEPTH)) | bus.out_ready_i;
  assign push      = bus.in_valid_i & in_ready;
  assign pop       = out_valid & bus.out_ready_i;
  assign wr_en     = push & ~bus.flush_i;
  assign wr_entry  = '{instr: bus.instr_i, next_pc: bus.next_pc_i};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q)));
      if (pop)  rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q)));
      count_d = count_q + COUNT_W'(push) - COUNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fd_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_entry)
  );

  // Empty queue presents a bubble rather than stale storage.
  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.instr_o     = out_valid ? rd_entry.instr   : NOP_INSTR;
  assign bus.next_pc_o   = out_valid ? rd_entry.next_pc : '0;
  assign bus.count_o     = count_q;

  a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= COUNT_W'(DEPTH));
  a_push_ready  : assert property (@(posedge clk_i) disable iff (rst_i)
    wr_en |-> in_ready);
  a_pop_nonempty: assert property (@(posedge clk_i) disable iff (rst_i)
    pop |-> (count_q != '0));

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: scenario tasks plus a queue-based scoreboard.
// Expected entries are pushed when the model sees an accepted write and popped when decode consumes.
module tb_fetch_decode_queue;
  import fd_pkg::*;

  localparam int W = 16;
  localparam int D = 4;

  logic clk;
  logic rst;

  fetch_decode_queue_if #(.REGI_SIZE(W), .DEPTH(D)) bus ();

  fetch_decode_queue #(.REGI_SIZE(W), .DEPTH(D), .NOP_INSTR(16'h0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2*W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int seen_c0de = 0;

  // One clock of stimulus; the scoreboard compares the head whenever decode consumes it.
  task automatic drive_cycle(input logic v, input logic [W-1:0] ins, input logic [W-1:0] pc,
                             input logic rdy, input logic fl, input logic rs);
    logic m_push;
    logic m_pop;
    logic [2*W-1:0] head;
    bus.in_valid_i  = v;
    bus.instr_i     = ins;
    bus.next_pc_i   = pc;
    bus.out_ready_i = rdy;
    bus.flush_i     = fl;
    rst             = rs;
    @(negedge clk);
    m_push = v && ((exp_q.size() < D) || rdy);
    m_pop  = rdy && (exp_q.size() != 0);
    if (bus.instr_o === 16'hC0DE) seen_c0de++;
    n_checks++;
    if (bus.in_ready_o !== ((exp_q.size() < D) || rdy))
      $display("FAIL in_ready: got %b want %b", bus.in_ready_o, ((exp_q.size() < D) || rdy));
    else n_pass++;
    n_checks++;
    if (bus.out_valid_o !== (exp_q.size() != 0))
      $display("FAIL out_valid: got %b want %b", bus.out_valid_o, (exp_q.size() != 0));
    else n_pass++;
    if (m_pop && !rs) begin
      head = exp_q[0];
      n_checks++;
      if ({bus.instr_o, bus.next_pc_o} !== head)
        $display("FAIL sb_head: got %h/%h want %h/%h", bus.instr_o, bus.next_pc_o,
                 head[2*W-1:W], head[W-1:0]);
      else n_pass++;
    end
    @(posedge clk);
    if (rs || fl) begin
      exp_q.delete();
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({ins, pc});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.instr_i = 16'h1234;
    bus.next_pc_i = 16'h0001;
    bus.out_ready_i = 1'b0;
    bus.flush_i = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 16'h1234 + W'(i), 16'h0001, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (bus.count_o !== 3'd0 || bus.out_valid_o !== 1'b0 ||
          bus.instr_o !== 16'h0 || bus.next_pc_o !== 16'h0)
        $display("FAIL reset_state: got cnt=%0d v=%b i=%h pc=%h want 0/0/0000/0000",
                 bus.count_o, bus.out_valid_o, bus.instr_o, bus.next_pc_o);
      else n_pass++;
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, 16'hA001 + W'(k), W'(k + 1), 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (bus.instr_o !== 16'hA001 || bus.count_o !== 3'(k + 1))
        $display("FAIL fill_step: got i=%h cnt=%0d want A001/%0d", bus.instr_o, bus.count_o, k + 1);
      else n_pass++;
    end
    n_checks++;
    if (bus.count_o !== 3'd4 || bus.in_ready_o !== 1'b0)
      $display("FAIL fill_full: got cnt=%0d rdy=%b want 4/0", bus.count_o, bus.in_ready_o);
    else n_pass++;
  endtask

  task automatic test_full_simul();
    drive_cycle(1'b1, 16'hA005, 16'd5, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.instr_o !== 16'hA002 || bus.next_pc_o !== 16'd2 || bus.count_o !== 3'd4)
      $display("FAIL full_simul: got i=%h pc=%h cnt=%0d want A002/0002/4",
               bus.instr_o, bus.next_pc_o, bus.count_o);
    else n_pass++;
  endtask

  task automatic test_drain_wrap();
    int k = 0;
    int budget = 200;
    while (exp_q.size() != 0) drive_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    while (k < 10 && budget > 0) begin
      logic v;
      logic r;
      v = 1'($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 3) != 0);
      drive_cycle(v, 16'hB000 + W'(k), 16'h0100 + W'(k), r, 1'b0, 1'b0);
      if (v && (exp_q.size() != 0) && exp_q[exp_q.size()-1][2*W-1:W] == 16'hB000 + W'(k)) k++;
      budget--;
    end
    n_checks++;
    if (k != 10) $display("FAIL wrap_budget: got %0d pushes want 10", k);
    else n_pass++;
    budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      drive_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      budget--;
    end
    n_checks++;
    if (bus.count_o !== 3'd0 || bus.instr_o !== 16'h0 || bus.out_valid_o !== 1'b0)
      $display("FAIL wrap_empty: got cnt=%0d i=%h v=%b want 0/0000/0",
               bus.count_o, bus.instr_o, bus.out_valid_o);
    else n_pass++;
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) drive_cycle(1'b1, 16'hE001 + W'(k), W'(k), 1'b0, 1'b0, 1'b0);
    seen_c0de = 0;
    drive_cycle(1'b1, 16'hC0DE, 16'h0077, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (bus.count_o !== 3'd0 || bus.out_valid_o !== 1'b0 || bus.instr_o !== 16'h0)
      $display("FAIL flush_state: got cnt=%0d v=%b i=%h want 0/0/0000",
               bus.count_o, bus.out_valid_o, bus.instr_o);
    else n_pass++;
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (seen_c0de != 0) $display("FAIL flush_leak: got %0d C0DE sightings want 0", seen_c0de);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) drive_cycle(1'b1, 16'hF001 + W'(k), W'(k), 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'hF0F0, 16'h0042, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (bus.count_o !== 3'd0 || bus.out_valid_o !== 1'b0 ||
        bus.instr_o !== 16'h0 || bus.next_pc_o !== 16'h0)
      $display("FAIL reset_mid: got cnt=%0d v=%b i=%h pc=%h want 0/0/0000/0000",
               bus.count_o, bus.out_valid_o, bus.instr_o, bus.next_pc_o);
    else n_pass++;
    drive_cycle(1'b1, 16'hD001, 16'h000D, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.instr_o !== 16'hD001 || bus.next_pc_o !== 16'h000D || bus.count_o !== 3'd1)
      $display("FAIL post_reset_push: got i=%h pc=%h cnt=%0d want D001/000D/1",
               bus.instr_o, bus.next_pc_o, bus.count_o);
    else n_pass++;
    drive_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d want 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_simul();
    test_drain_wrap();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
